// File: rtl/cfg_bus_sched.sv
`timescale 1ns/1ps
// cfg_bus_sched: scheduler and master for the shared configuration bus that
// feeds the clock divider, UART and VGA blocks. It arbitrates round-robin
// between the command manager (requester 0) and the local preset/debug path
// (requester 1). It issues one bus transaction at a time and waits for every
// target to report ready. A timeout bounds each transaction, and the owning
// requester gets a done or error pulse at the end.
//
// Ports:
//   clk, rst                  single clock, asynchronous active-high reset
//   rq0_valid/addr/data       requester 0 transaction request
//   rq0_ready                 requester 0 accepted this cycle (combinational)
//   rq1_valid/addr/data       requester 1 transaction request
//   rq1_ready                 requester 1 accepted this cycle (combinational)
//   rsp_done[1:0]             one-cycle completion pulse, bit = requester
//   rsp_err[1:0]              one-cycle timeout pulse, bit = requester
//   c_valid/c_addr/c_data     configuration bus master outputs
//   c_ready[N_TGT-1:0]        per-target ready
//   busy                      scheduler is not idle
//   err_cnt[7:0]              saturating timeout count since reset
module cfg_bus_sched #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 14,
  parameter int N_TGT   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rq0_valid,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_data,
  output logic              rq0_ready,
  input  logic              rq1_valid,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_data,
  output logic              rq1_ready,
  output logic [1:0]        rsp_done,
  output logic [1:0]        rsp_err,
  output logic              c_valid,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_data,
  input  logic [N_TGT-1:0]  c_ready,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  // Counter runs 0..TIMEOUT-1, so clog2(TIMEOUT) bits are enough.
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state_r,   state_s;
  logic               c_valid_r, c_valid_s;
  logic [ADDR_W-1:0]  c_addr_r,  c_addr_s;
  logic [DATA_W-1:0]  c_data_r,  c_data_s;
  logic               owner_r,   owner_s;
  logic               last_r,    last_s;    // requester served most recently
  logic [CNT_W-1:0]   cnt_r,     cnt_s;
  logic [1:0]         done_r,    done_s;
  logic [1:0]         err_r,     err_s;
  logic [7:0]         err_cnt_r, err_cnt_s;
  logic [1:0]         gnt_s;
  logic               all_ready_s;
  logic               timeout_s;

  assign all_ready_s = &c_ready;
  assign timeout_s   = (cnt_r == CNT_LAST) && !all_ready_s;

  // Round-robin grant, offered only while idle.
  always_comb begin
    gnt_s = 2'b00;
    if (state_r == ST_IDLE) begin
      if (rq0_valid && rq1_valid) begin
        // On contention, serve the requester that was not served last.
        gnt_s = last_r ? 2'b01 : 2'b10;
      end else if (rq0_valid) begin
        gnt_s = 2'b01;
      end else if (rq1_valid) begin
        gnt_s = 2'b10;
      end else begin
        gnt_s = 2'b00;
      end
    end else begin
      gnt_s = 2'b00;
    end
  end

  assign rq0_ready = gnt_s[0];
  assign rq1_ready = gnt_s[1];

  // Next-state and next-output logic of the transaction FSM.
  always_comb begin
    state_s   = state_r;
    c_valid_s = c_valid_r;
    c_addr_s  = c_addr_r;
    c_data_s  = c_data_r;
    owner_s   = owner_r;
    last_s    = last_r;
    cnt_s     = cnt_r;
    done_s    = 2'b00;
    err_s     = 2'b00;
    err_cnt_s = err_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_s != 2'b00) begin
          c_valid_s = 1'b1;
          c_addr_s  = gnt_s[1] ? rq1_addr : rq0_addr;
          c_data_s  = gnt_s[1] ? rq1_data : rq0_data;
          owner_s   = gnt_s[1];
          last_s    = gnt_s[1];
          cnt_s     = {CNT_W{1'b0}};
          state_s   = ST_ISSUE;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // c_ready is only looked at here, where c_valid is high; completion
        // is checked first so it beats a simultaneous timeout.
        if (all_ready_s) begin
          c_valid_s = 1'b0;
          done_s    = owner_r ? 2'b10 : 2'b01;
          state_s   = ST_GAP;
        end else if (timeout_s) begin
          c_valid_s = 1'b0;
          err_s     = owner_r ? 2'b10 : 2'b01;
          err_cnt_s = (err_cnt_r == 8'hFF) ? err_cnt_r : (err_cnt_r + 8'd1);
          state_s   = ST_GAP;
        end else begin
          cnt_s     = cnt_r + CNT_W'(1);
        end
      end
      ST_GAP: begin
        state_s = ST_IDLE;
      end
      default: begin
        c_valid_s = 1'b0;
        state_s   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops c_valid immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      c_valid_r <= 1'b0;
      c_addr_r  <= {ADDR_W{1'b0}};
      c_data_r  <= {DATA_W{1'b0}};
      owner_r   <= 1'b0;
      last_r    <= 1'b1;          // pretend requester 1 went last so 0 wins first
      cnt_r     <= {CNT_W{1'b0}};
      done_r    <= 2'b00;
      err_r     <= 2'b00;
      err_cnt_r <= 8'd0;
    end else begin
      state_r   <= state_s;
      c_valid_r <= c_valid_s;
      c_addr_r  <= c_addr_s;
      c_data_r  <= c_data_s;
      owner_r   <= owner_s;
      last_r    <= last_s;
      cnt_r     <= cnt_s;
      done_r    <= done_s;
      err_r     <= err_s;
      err_cnt_r <= err_cnt_s;
    end
  end

  assign c_valid  = c_valid_r;
  assign c_addr   = c_addr_r;
  assign c_data   = c_data_r;
  assign rsp_done = done_r;
  assign rsp_err  = err_r;
  assign err_cnt  = err_cnt_r;
  assign busy     = (state_r != ST_IDLE);

endmodule

// File: doc/cfg_bus_sched.md
Name: cfg_bus_sched

Overview:
- Scheduler and master for the shared configuration bus (c_valid, 4-bit c_addr, 14-bit c_data, 3-bit c_ready) that feeds the clock divider, UART and VGA blocks.
- Arbitrates round-robin between two requesters:
  - requester 0: command manager path (UART-decoded commands).
  - requester 1: local preset/debug path (button-driven presets).
- Issues one transaction at a time, waits for all targets ready, enforces a timeout, and reports completion or error to the owning requester.

Parameters:
ADDR_W, 4, configuration address width
DATA_W, 14, configuration data width
N_TGT, 3, number of targets (width of c_ready)
TIMEOUT, 255, max cycles c_valid may stay high without completion (>=2)

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  reset, asynchronous, active-high
rq0_valid  in  1  requester 0 has a transaction
rq0_addr  in  ADDR_W  requester 0 address
rq0_data  in  DATA_W  requester 0 data
rq0_ready  out  1  requester 0 transaction accepted this cycle
rq1_valid  in  1  requester 1 has a transaction
rq1_addr  in  ADDR_W  requester 1 address
rq1_data  in  DATA_W  requester 1 data
rq1_ready  out  1  requester 1 transaction accepted this cycle
rsp_done  out  2  one-cycle pulse, bit i = requester i transaction completed
rsp_err  out  2  one-cycle pulse, bit i = requester i transaction timed out
c_valid  out  1  configuration bus valid
c_addr  out  ADDR_W  configuration bus address
c_data  out  DATA_W  configuration bus data
c_ready  in  N_TGT  per-target ready
busy  out  1  high whenever state != IDLE
err_cnt  out  8  saturating count of timeouts since reset

Behaviour:
- Reset values (asynchronous, immediate on rst=1):
  - state=IDLE; c_valid=0; c_addr=0; c_data=0.
  - rsp_done=0; rsp_err=0; err_cnt=0.
  - RR pointer favours requester 0.
- FSM states: IDLE, ISSUE, GAP.
- IDLE:
  - rqX_ready is combinational and is high only in IDLE, for the granted requester.
  - Grant rules:
    - only one requester valid -> it is granted.
    - both valid -> the one not served last is granted; first after reset is requester 0.
  - On the grant edge:
    - latch addr/data into c_addr/c_data.
    - record owner; update RR pointer.
    - clear timeout counter; go to ISSUE.
- ISSUE:
  - c_valid=1; c_addr/c_data held stable for the whole state.
  - Completion is when &c_ready==1 is sampled with c_valid=1. On completion:
    - next cycle c_valid=0.
    - rsp_done[owner] pulses for exactly 1 cycle.
    - go to GAP.
  - Otherwise the counter increments. Timeout is when the counter==TIMEOUT-1 and c_ready is not all ones. On timeout:
    - next cycle c_valid=0.
    - rsp_err[owner] pulses for 1 cycle.
    - err_cnt increments, saturating at 255.
    - go to GAP.
  - Completion and timeout in the same cycle: completion wins, no error.
  - c_valid is high for at most TIMEOUT consecutive cycles.
- GAP:
  - exactly 1 cycle with c_valid=0, guaranteeing a bus idle cycle between transactions.
  - then IDLE. No grant is possible in GAP (rqX_ready=0).
- Latency, with a grant at edge T:
  - c_valid high T+1.
  - if targets ready at T+1: rsp_done high T+2, IDLE at T+3.
  - back-to-back throughput is one transaction per 3 cycles.
- Requester contract:
  - rqX_addr/data are sampled only on the accept edge; later changes are ignored.
  - a requester deasserting valid before accept is legal; nothing is issued.
- c_addr/c_data retain their last values after completion; c_valid alone qualifies them.
- rsp_done and rsp_err are never both high, and never for a non-owner.
- rst asserted mid-ISSUE:
  - c_valid drops immediately; no done/err pulse.
  - the owner's transaction is lost; requesters must re-request.
- Ready bits sampled while c_valid=0 are ignored.

Test Plan:
- Single write: rq0 addr=4'h5 data=14'h0123; c_ready=3'b111 -> rq0_ready 1 cycle; c_valid high exactly 1 cycle with addr 5 / data 0123; rsp_done=2'b01 two cycles after accept.
- Contention: rq0 and rq1 both valid continuously, c_ready=111 -> grants alternate 0,1,0,1 starting with 0; accepts spaced 3 cycles; each done pulse on the correct bit.
- Slow target: c_ready=3'b011 for 10 cycles, then 111 -> c_valid high 11 cycles, addr/data stable throughout; single rsp_done; rsp_err=0.
- Timeout with TIMEOUT=8: c_ready stuck at 3'b101 -> c_valid high exactly 8 cycles; rsp_err[owner] 1 cycle; err_cnt=1; next request is served normally.
- Ready on the last timeout cycle: &c_ready rises exactly at counter=TIMEOUT-1 -> rsp_done, no rsp_err; err_cnt unchanged.
- Reset mid-transaction: assert rst during ISSUE -> c_valid=0 asynchronously; no pulses; after release rq1 and rq0 both valid -> rq0 granted first.
